// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline-stage register with 2-entry skid buffer, flush, bubble masking and stall counter
module pipe_stage_reg #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              in_ready_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CNT_W-1:0]  stall_q;
    logic              acc;
    logic              deq;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;

    assign out_valid   = (state != ST_EMPTY);
    assign in_ready    = in_ready_q;
    assign acc         = in_valid && in_ready_q;
    assign deq         = out_valid && out_ready;
    assign out_ctrl    = main_ctrl & {CTRL_W{out_valid}};
    assign out_data    = main_data;
    assign stall_count = stall_q;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (acc) begin
                    load_main = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && deq) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    load_skid = 1'b1;
                    state_nxt = ST_TWO;
                end else if (deq) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deq) begin
                    main_from_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush wins over everything, including an entry accepted this cycle.
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_TWO);
            if (load_main) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (main_from_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed vector bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [68:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ctrl;
    logic [68:0] out_data;
    logic [15:0] stall_count;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [1:0]  s_in_ctrl;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [1:0]  s_out_ctrl;
    logic [7:0]  s_out_data;
    logic [3:0]  s_stall_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_count(stall_count)
    );

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .stall_count(s_stall_count)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [1:0]  ctrl;
        logic [68:0] data;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_ctrl;
        logic [68:0] e_data;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic iv, input logic ordy, input logic fl, input logic [1:0] ctrl,
                        input logic [68:0] data, input logic e_ov, input logic e_ir,
                        input logic [1:0] e_ctrl, input logic [68:0] e_data, input logic [15:0] e_stall);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = ctrl; v.data = data;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_ctrl = e_ctrl; v.e_data = e_data; v.e_stall = e_stall;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_ctrl = '0; s_in_data = '0; s_out_ready = 1'b1;

        // Streaming 1..8 at full rate.
        for (int k = 1; k <= 8; k++) addv(1, 1, 0, 2'b01, 69'(k), 1, 1, 2'b01, 69'(k), 0);
        addv(0, 1, 0, 2'b00, 69'h0,  0, 1, 2'b00, 69'h0,  0);
        // Backpressure into skid; C offered while in_ready==0 must be ignored.
        addv(1, 0, 0, 2'b10, 69'hA,  1, 1, 2'b10, 69'hA,  0);
        addv(1, 0, 0, 2'b11, 69'hB,  1, 0, 2'b10, 69'hA,  1);
        addv(1, 0, 0, 2'b01, 69'hC,  1, 0, 2'b10, 69'hA,  2);
        addv(0, 0, 0, 2'b00, 69'h0,  1, 0, 2'b10, 69'hA,  3);
        addv(0, 1, 0, 2'b00, 69'h0,  1, 1, 2'b11, 69'hB,  3);
        addv(0, 1, 0, 2'b00, 69'h0,  0, 1, 2'b00, 69'h0,  3);
        // Flush from TWO, then flush in ONE with a same-cycle accept.
        addv(1, 0, 0, 2'b11, 69'h11, 1, 1, 2'b11, 69'h11, 3);
        addv(1, 0, 0, 2'b01, 69'h22, 1, 0, 2'b11, 69'h11, 4);
        addv(1, 0, 1, 2'b10, 69'h33, 0, 1, 2'b00, 69'h0,  5);
        addv(0, 1, 0, 2'b00, 69'h0,  0, 1, 2'b00, 69'h0,  5);
        addv(1, 1, 0, 2'b01, 69'h44, 1, 1, 2'b01, 69'h44, 5);
        addv(1, 1, 1, 2'b10, 69'h55, 0, 1, 2'b00, 69'h0,  5);
        addv(0, 1, 0, 2'b00, 69'h0,  0, 1, 2'b00, 69'h0,  5);
        // Bubble masking of control.
        addv(1, 1, 0, 2'b11, 69'h66, 1, 1, 2'b11, 69'h66, 5);
        addv(0, 1, 0, 2'b11, 69'h67, 0, 1, 2'b00, 69'h0,  5);
        addv(0, 1, 0, 2'b00, 69'h0,  0, 1, 2'b00, 69'h0,  5);
        // ONE hold, then drain.
        addv(1, 0, 0, 2'b01, 69'h77, 1, 1, 2'b01, 69'h77, 5);
        addv(0, 0, 0, 2'b00, 69'h0,  1, 1, 2'b01, 69'h77, 6);
        addv(0, 1, 0, 2'b00, 69'h0,  0, 1, 2'b00, 69'h0,  6);

        step(); step();
        chk("reset out_valid", 128'(out_valid), 128'(1'b0));
        chk("reset in_ready", 128'(in_ready), 128'(1'b1));
        chk("reset out_ctrl", 128'(out_ctrl), 128'(2'b00));
        chk("reset out_data", 128'(out_data), 128'(69'h0));
        chk("reset stall_count", 128'(stall_count), 128'(16'h0));
        rst = 1'b1;

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv; out_ready = vecs[i].ordy; flush = vecs[i].fl;
            in_ctrl = vecs[i].ctrl; in_data = vecs[i].data;
            step();
            chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(vecs[i].e_ov));
            chk($sformatf("v%0d in_ready", i), 128'(in_ready), 128'(vecs[i].e_ir));
            chk($sformatf("v%0d out_ctrl", i), 128'(out_ctrl), 128'(vecs[i].e_ctrl));
            if (vecs[i].e_ov) chk($sformatf("v%0d out_data", i), 128'(out_data), 128'(vecs[i].e_data));
            chk($sformatf("v%0d stall_count", i), 128'(stall_count), 128'(vecs[i].e_stall));
        end
        in_valid = 1'b0; flush = 1'b0;

        // Saturation on the CNT_W=4 instance.
        s_in_valid = 1'b1; s_in_data = 8'h5A; s_in_ctrl = 2'b10; s_out_ready = 1'b0;
        step();
        s_in_valid = 1'b0;
        chk("sat out_valid", 128'(s_out_valid), 128'(1'b1));
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 14) chk("sat count 14", 128'(s_stall_count), 128'(4'd14));
            if (n == 15) chk("sat count 15", 128'(s_stall_count), 128'(4'd15));
            if (n == 20) chk("sat count held", 128'(s_stall_count), 128'(4'd15));
        end
        chk("sat data held", 128'(s_out_data), 128'(8'h5A));

        // Asynchronous reset while holding two entries.
        in_valid = 1'b1; in_ctrl = 2'b11; in_data = 69'h88; out_ready = 1'b0;
        step();
        in_data = 69'h99;
        step();
        chk("pre-reset in_ready", 128'(in_ready), 128'(1'b0));
        #2 rst = 1'b0;
        #1;
        chk("async out_valid", 128'(out_valid), 128'(1'b0));
        chk("async out_ctrl", 128'(out_ctrl), 128'(2'b00));
        chk("async out_data", 128'(out_data), 128'(69'h0));
        chk("async in_ready", 128'(in_ready), 128'(1'b1));
        chk("async stall_count", 128'(stall_count), 128'(16'h0));
        chk("async sat stall_count", 128'(s_stall_count), 128'(4'd0));
        step();
        chk("held reset out_valid", 128'(out_valid), 128'(1'b0));
        rst = 1'b1; in_data = 69'hAB; in_ctrl = 2'b01; out_ready = 1'b1;
        step();
        chk("first accept out_valid", 128'(out_valid), 128'(1'b1));
        chk("first accept out_data", 128'(out_data), 128'(69'hAB));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
